// File: rtl/accum_sequencer.sv
// Control sequencer for an 8-bit accumulator datapath: turns one instruction at a
// time into registered load strobes, bus enables and completion/flag outputs.
module accum_sequencer #(
  parameter int OUT_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [2:0] opcode,
  input  logic       cf_i,
  input  logic       zf_i,
  output logic       nLa,
  output logic       nLb,
  output logic       Ea,
  output logic       Eu,
  output logic       sub,
  output logic       out_sel,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       cf,
  output logic       zf
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDA = 3'b001;
  localparam logic [2:0] OP_LDB = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_OUT = 3'b101;

  // Out-of-range hold lengths collapse to a single OUT cycle.
  localparam int HOLD = (OUT_HOLD < 1 || OUT_HOLD > 15) ? 1 : OUT_HOLD;
  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_LOADA, S_LOADB, S_EXEC1, S_EXEC2, S_OUT, S_DONE_NOP
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;

  logic ready_q, nLa_q, nLb_q, Ea_q, Eu_q, sub_q, outSel_q, done_q, err_q, cf_q, zf_q;
  logic ready_d, nLa_d, nLb_d, Ea_d, Eu_d, sub_d, outSel_d, done_d, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      op_q     <= OP_NOP;
      ready_q  <= 1'b1;
      nLa_q    <= 1'b1;
      nLb_q    <= 1'b1;
      Ea_q     <= 1'b0;
      Eu_q     <= 1'b0;
      sub_q    <= 1'b0;
      outSel_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      ready_q  <= ready_d;
      nLa_q    <= nLa_d;
      nLb_q    <= nLb_d;
      Ea_q     <= Ea_d;
      Eu_q     <= Eu_d;
      sub_q    <= sub_d;
      outSel_q <= outSel_d;
      done_q   <= done_d;
      err_q    <= err_d;
      // Flags follow the ALU result that is written back at the end of EXEC2.
      if (state_q == S_EXEC2) begin
        cf_q <= cf_i;
        zf_q <= zf_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d = opcode;
          case (opcode)
            OP_LDA, OP_LDB, OP_ADD, OP_SUB: state_d = S_WAIT;
            OP_OUT: begin
              state_d = S_OUT;
              cnt_d   = HOLD_LAST;
            end
            default: state_d = S_DONE_NOP;
          endcase
        end
      end
      S_WAIT:     state_d = (op_q == OP_LDA) ? S_LOADA : S_LOADB;
      S_LOADA:    state_d = S_IDLE;
      S_LOADB:    state_d = (op_q == OP_ADD || op_q == OP_SUB) ? S_EXEC1 : S_IDLE;
      S_EXEC1:    state_d = S_EXEC2;
      S_EXEC2:    state_d = S_IDLE;
      S_OUT: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DONE_NOP: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Decoding the next state lets every control output come straight from a flop.
  always_comb begin
    ready_d  = (state_d == S_IDLE);
    nLa_d    = !(state_d == S_LOADA || state_d == S_EXEC2);
    nLb_d    = !(state_d == S_LOADB);
    Eu_d     = (state_d == S_EXEC1 || state_d == S_EXEC2);
    sub_d    = Eu_d && (op_d == OP_SUB);
    Ea_d     = (state_d == S_OUT);
    outSel_d = (state_d == S_OUT);
    done_d   = (state_d == S_LOADA)
            || (state_d == S_LOADB && op_d == OP_LDB)
            || (state_d == S_EXEC2)
            || (state_d == S_OUT && cnt_d == 4'd0)
            || (state_d == S_DONE_NOP);
    err_d    = (state_d == S_DONE_NOP) && (op_d[2:1] == 2'b11);
  end

  assign instr_ready = ready_q;
  assign busy        = !ready_q;
  assign nLa         = nLa_q;
  assign nLb         = nLb_q;
  assign Ea          = Ea_q;
  assign Eu          = Eu_q;
  assign sub         = sub_q;
  assign out_sel     = outSel_q;
  assign done        = done_q;
  assign err         = err_q;
  assign cf          = cf_q;
  assign zf          = zf_q;

endmodule

// File: doc/accum_sequencer.md
ACCUM_SEQUENCER -- requirements
Module: accum_sequencer

Interface
REQ-001 Parameter: OUT_HOLD, 1, number of cycles (1..15) the OUT opcode drives A onto the bus.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 instr_valid  input  1  requester presents an instruction.
REQ-005 instr_ready  output  1  sequencer can accept an instruction this cycle.
REQ-006 opcode  input  3  000 NOP, 001 LDA, 010 LDB, 011 ADD, 100 SUB, 101 OUT, 110/111 illegal.
REQ-007 cf_i, zf_i  input  1 each  carry and zero flags from the ALU.
REQ-008 nLa, nLb  output  1 each  active-low load strobes for register A and register B.
REQ-009 Ea, Eu  output  1 each  active-high bus drive enables for register A and ALU result.
REQ-010 sub  output  1  ALU subtract select.
REQ-011 out_sel  output  1  pad mux select, 1 = bus, 0 = register A.
REQ-012 busy, done, err  output  1 each  instruction in flight / one-cycle completion pulse / one-cycle illegal-opcode pulse.
REQ-013 cf, zf  output  1 each  flags latched at the last ADD/SUB.

Function
REQ-014 All outputs are registered; the control outputs are glitch-free state decodes.
REQ-015 An instruction is accepted on a posedge where instr_valid=1 and instr_ready=1; call that cycle C0.
REQ-016 instr_ready=1 only in IDLE; busy = !instr_ready.
REQ-017 The requester holds the operand on the input bus stable from C0 until done.
REQ-018 States: IDLE, WAIT, LOADA, LOADB, EXEC1, EXEC2, OUT, DONE_NOP.
REQ-019 WAIT is one cycle with all controls inactive, covering the one-cycle input-buffer latency.
REQ-020 LDA: C1 WAIT; C2 LOADA (nLa=0, done=1); then IDLE.
REQ-021 LDB: C1 WAIT; C2 LOADB (nLb=0, done=1); then IDLE.
REQ-022 ADD/SUB step 1: C1 WAIT; C2 LOADB (nLb=0).
REQ-023 ADD/SUB step 2: C3 EXEC1 (Eu=1, sub=opcode==SUB).
REQ-024 ADD/SUB step 3: C4 EXEC2 (Eu=1, sub held, nLa=0, done=1); then IDLE.
REQ-025 ADD/SUB flags: cf<=cf_i and zf<=zf_i on the posedge ending EXEC2.
REQ-026 ADD/SUB wrap-around: A wraps mod 256 and cf reflects the carry/borrow; the sequencer does not saturate.
REQ-027 OUT: C1..C(OUT_HOLD) OUT state with Ea=1 and out_sel=1; done=1 in the final OUT cycle; then IDLE.
REQ-028 NOP: C1 DONE_NOP (done=1); then IDLE.
REQ-029 Illegal opcode: behaves as NOP; err=1 in the same cycle as done.
REQ-030 Ea and Eu are never 1 in the same cycle.
REQ-031 nLa and nLb are never both 0.
REQ-032 nLa/nLb are never 0 while the bus source is undriven by the intended source.
REQ-033 Back-to-back: IDLE is re-entered the cycle after done, so the minimum issue interval equals latency+1.
REQ-034 instr_valid and opcode are ignored while busy; no queuing.
REQ-035 OUT_HOLD outside 1..15 is clamped to 1 (OUT_HOLD=0 behaves as 1).

Reset
REQ-036 With rst=1 at a posedge, the next state is IDLE regardless of state, aborting any instruction mid-operation.
REQ-037 Values after a reset edge: nLa=nLb=1, Ea=Eu=sub=out_sel=0, busy=done=err=0, cf=zf=0, instr_ready=1.
REQ-038 rst has priority over an instruction accepted on the same edge; that instruction is dropped.
REQ-039 Reset mid-ADD (during EXEC1) produces no nLa pulse and no done pulse, and leaves cf/zf at 0.

Verification
REQ-040 Scenario 1: LDA 0x05, LDB 0x03, ADD 0x03 -> A=0x08; ADD done at C4 exactly; cf=0, zf=0.
REQ-041 Scenario 2: LDA 0xFF, ADD 0x01 -> A=0x00; cf=1, zf=1; nLa low for exactly one cycle, in EXEC2.
REQ-042 Scenario 3: LDA 0x03, SUB 0x03 -> A=0x00, zf=1, sub=1 during EXEC1/EXEC2 only.
REQ-043 Scenario 3, OUT with OUT_HOLD=3: Ea=1 and out_sel=1 for exactly 3 cycles; done on the third.
REQ-044 Scenario 4: opcode 111 -> done and err at C1, no strobes, instr_ready high at C2.
REQ-045 Scenario 4: instr_valid held high continuously -> instructions accepted only when instr_ready=1, one per completion.
REQ-046 Scenario 5: rst asserted during EXEC1 of ADD -> next cycle IDLE, all controls inactive, A unchanged from the pre-ADD value.
REQ-047 Scenario 6: a random opcode stream of 1000 instructions -> assertion checks hold for REQ-030 to REQ-032 every cycle, and A matches a reference model.
